// File: rtl/conv_img2col_stream_if.sv
// AXI-Stream bundle for the Img2Col front-end: one instance per stream direction.
interface conv_img2col_stream_if #(
  parameter int unsigned DATA_W = 64
);
  logic [DATA_W-1:0]   tdata;
  logic                tvalid;
  logic                tready;
  logic                tlast;
  logic [DATA_W/8-1:0] tkeep;

  modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/conv_img2col_stream.sv
// Streaming Img2Col: buffers K input rows in a circular row RAM and replays kernel
// windows to the MAC array; bypass mode forwards the input stream unchanged.
module conv_img2col_stream #(
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned MAX_K         = 3,
  parameter int unsigned MAX_ROW_BEATS = 2048,
  parameter int unsigned GROUP_W       = 8,
  parameter int unsigned CFG_W         = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Control_start,
  input  logic                   Control_Switch_Conv,
  input  logic                   Control_Matrix2Img,
  conv_img2col_stream_if.slave   s_axis_s2mm,
  conv_img2col_stream_if.master  m_axis_mm2s,
  input  logic [CFG_W-1:0]       Img2Col_Stride,
  input  logic [CFG_W-1:0]       Img2Col_Kernel_Size,
  input  logic [CFG_W-1:0]       Img2Col_Window_Size,
  input  logic [CFG_W-1:0]       Img2Col_InFeature_Size,
  input  logic [CFG_W-1:0]       Img2Col_InFeature_Channel,
  input  logic [CFG_W-1:0]       Img2Col_OutFeature_Channel,
  input  logic [CFG_W-1:0]       Img2Col_OutFeature_Size,
  input  logic [CFG_W-1:0]       Img2Col_Sliding_Size,
  input  logic [CFG_W-1:0]       Img2Col_OutCol_Count_Times,
  input  logic [CFG_W-1:0]       Img2Col_InCol_Count_Times,
  input  logic [CFG_W-1:0]       Img2Col_OutRow_Count_Times,
  input  logic [CFG_W-1:0]       Img2Col_OutFeature_Channel_Count_Times,
  input  logic [CFG_W-1:0]       Img2Col_WeightMatrix_Row
);
  localparam int unsigned ADDR_W  = $clog2(MAX_K * MAX_ROW_BEATS);
  localparam int unsigned SLOT_W  = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam logic [CFG_W-1:0] CFG_ONE = CFG_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EMIT, ST_DONE} state_t;
  state_t state, state_next;

  logic [CFG_W-1:0] k, s, win, slide, outcol, incol, outrow, rep, wm_beats;
  logic [CFG_W-1:0] col_in, rows_in, r, g, p, w, kr, b, wb, win_col, grp_col;
  logic [SLOT_W-1:0] wr_slot, base, rd_slot;
  logic [DATA_W-1:0] ram [MAX_K*MAX_ROW_BEATS];
  logic [DATA_W-1:0] rd_data, out_data;
  logic p1_v, p1_last, out_v, out_last;

  logic bypass, start_i2c, load_fire, load_done, issue, p1_move, p1_free;
  logic win_end, w_end, p_end, g_end, row_end, last_row;
  logic [CFG_W-1:0] rows_need, grp_step, base_sum, rd_col;
  logic [SLOT_W-1:0] base_nx;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  logic unused_cfg;
  assign unused_cfg = ^{Img2Col_InFeature_Size, Img2Col_InFeature_Channel,
                        Img2Col_OutFeature_Channel, Img2Col_OutFeature_Size};

  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] x,
                                                 input logic [CFG_W-1:0] kk);
    return (CFG_W'(x) == kk - CFG_ONE) ? '0 : x + SLOT_W'(1);
  endfunction

  always_comb begin
    bypass    = !Control_Switch_Conv || Control_Matrix2Img;
    start_i2c = Control_start && !bypass;
    load_fire = (state == ST_LOAD) && !start_i2c && !bypass && s_axis_s2mm.tvalid;
    rows_need = (r == '0) ? k : s;
    load_done = load_fire && (col_in == incol - CFG_ONE) && (rows_in + CFG_ONE == rows_need);
    // Two-stage read pipeline (RAM register, output register) advances only into free space
    p1_move   = p1_v && (!out_v || m_axis_mm2s.tready);
    p1_free   = !p1_v || p1_move;
    issue     = (state == ST_EMIT) && !start_i2c && !bypass && p1_free;
    win_end   = (wb == wm_beats - CFG_ONE);
    w_end     = (w == CFG_W'(GROUP_W - 1));
    p_end     = (p == rep - CFG_ONE);
    g_end     = (g == outcol - CFG_ONE);
    row_end   = win_end && w_end && p_end && g_end;
    last_row  = (r == outrow - CFG_ONE);
    grp_step  = slide * CFG_W'(GROUP_W);
    base_sum  = CFG_W'(base) + s;
    base_nx   = (base_sum >= k) ? SLOT_W'(base_sum - k) : SLOT_W'(base_sum);
    rd_col    = win_col + b;
    wr_addr   = ADDR_W'(wr_slot) * ADDR_W'(MAX_ROW_BEATS) + ADDR_W'(col_in);
    rd_addr   = ADDR_W'(rd_slot) * ADDR_W'(MAX_ROW_BEATS) + ADDR_W'(rd_col);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start_i2c) state_next = ST_LOAD;
    else if (bypass) state_next = ST_IDLE;
    else begin
      case (state)
        ST_LOAD: if (load_done) state_next = ST_EMIT;
        ST_EMIT: if (issue && row_end) state_next = last_row ? ST_DONE : ST_LOAD;
        default: state_next = state;
      endcase
    end

    s_axis_s2mm.tready = 1'b0;
    m_axis_mm2s.tdata  = '0;
    m_axis_mm2s.tvalid = 1'b0;
    m_axis_mm2s.tlast  = 1'b0;
    m_axis_mm2s.tkeep  = '1;
    if (reset) begin
      s_axis_s2mm.tready = 1'b0;
    end else if (bypass) begin
      m_axis_mm2s.tdata  = s_axis_s2mm.tdata;
      m_axis_mm2s.tvalid = s_axis_s2mm.tvalid;
      s_axis_s2mm.tready = m_axis_mm2s.tready;
    end else begin
      s_axis_s2mm.tready = (state == ST_LOAD) && !start_i2c;
      m_axis_mm2s.tdata  = out_data;
      m_axis_mm2s.tvalid = out_v && !start_i2c;
      m_axis_mm2s.tlast  = out_v && out_last && !start_i2c;
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) ram[wr_addr] <= s_axis_s2mm.tdata;
    if (issue)     rd_data      <= ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset || start_i2c) begin
      col_in <= '0; rows_in <= '0; wr_slot <= '0; base <= '0; rd_slot <= '0;
      r <= '0; g <= '0; p <= '0; w <= '0; kr <= '0; b <= '0; wb <= '0;
      win_col <= '0; grp_col <= '0;
      p1_v <= 1'b0; p1_last <= 1'b0; out_v <= 1'b0; out_last <= 1'b0;
      if (reset) begin
        out_data <= '0;
        k <= '0; s <= '0; win <= '0; slide <= '0; outcol <= '0;
        incol <= '0; outrow <= '0; rep <= '0; wm_beats <= '0;
      end else begin
        k        <= Img2Col_Kernel_Size;
        s        <= Img2Col_Stride;
        win      <= Img2Col_Window_Size;
        slide    <= Img2Col_Sliding_Size;
        outcol   <= Img2Col_OutCol_Count_Times;
        incol    <= Img2Col_InCol_Count_Times;
        outrow   <= Img2Col_OutRow_Count_Times;
        rep      <= Img2Col_OutFeature_Channel_Count_Times;
        wm_beats <= Img2Col_WeightMatrix_Row >> 3;
      end
    end else if (bypass) begin
      p1_v  <= 1'b0;
      out_v <= 1'b0;
    end else begin
      if (load_fire) begin
        if (col_in == incol - CFG_ONE) begin
          col_in  <= '0;
          wr_slot <= slot_inc(wr_slot, k);
          rows_in <= load_done ? '0 : rows_in + CFG_ONE;
        end else begin
          col_in <= col_in + CFG_ONE;
        end
      end

      if (issue) begin
        p1_last <= row_end && last_row;
        if (win_end) begin
          wb <= '0; b <= '0; kr <= '0; rd_slot <= base;
          if (!w_end) begin
            w <= w + CFG_ONE; win_col <= win_col + slide;
          end else begin
            w <= '0;
            if (!p_end) begin
              p <= p + CFG_ONE; win_col <= grp_col;
            end else begin
              p <= '0;
              if (!g_end) begin
                g <= g + CFG_ONE; grp_col <= grp_col + grp_step; win_col <= grp_col + grp_step;
              end else begin
                g <= '0; grp_col <= '0; win_col <= '0;
                r <= r + CFG_ONE; base <= base_nx; rd_slot <= base_nx;
              end
            end
          end
        end else begin
          wb <= wb + CFG_ONE;
          if (b != win - CFG_ONE) begin
            b <= b + CFG_ONE;
          end else begin
            b <= '0; kr <= kr + CFG_ONE; rd_slot <= slot_inc(rd_slot, k);
          end
        end
      end

      if (issue)        p1_v <= 1'b1;
      else if (p1_move) p1_v <= 1'b0;

      if (p1_move) begin
        out_data <= rd_data;
        out_last <= p1_last;
        out_v    <= 1'b1;
      end else if (out_v && m_axis_mm2s.tready) begin
        out_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_img2col_stream.sv
// Directed bench for conv_img2col_stream: bypass, Img2Col frames, backpressure, restart.
module tb_conv_img2col_stream;
  logic clk = 1'b0;
  logic reset, start, sw_conv, m2i;
  logic [15:0] c_stride, c_k, c_win, c_infs, c_inch, c_outch, c_outfs, c_slide;
  logic [15:0] c_outcol, c_incol, c_outrow, c_rep, c_wm;

  conv_img2col_stream_if #(.DATA_W(64)) s_if ();
  conv_img2col_stream_if #(.DATA_W(64)) m_if ();

  conv_img2col_stream #(.DATA_W(64), .MAX_K(3), .MAX_ROW_BEATS(2048), .GROUP_W(8), .CFG_W(16)) dut (
    .clk(clk), .reset(reset),
    .Control_start(start), .Control_Switch_Conv(sw_conv), .Control_Matrix2Img(m2i),
    .s_axis_s2mm(s_if), .m_axis_mm2s(m_if),
    .Img2Col_Stride(c_stride), .Img2Col_Kernel_Size(c_k), .Img2Col_Window_Size(c_win),
    .Img2Col_InFeature_Size(c_infs), .Img2Col_InFeature_Channel(c_inch),
    .Img2Col_OutFeature_Channel(c_outch), .Img2Col_OutFeature_Size(c_outfs),
    .Img2Col_Sliding_Size(c_slide), .Img2Col_OutCol_Count_Times(c_outcol),
    .Img2Col_InCol_Count_Times(c_incol), .Img2Col_OutRow_Count_Times(c_outrow),
    .Img2Col_OutFeature_Channel_Count_Times(c_rep), .Img2Col_WeightMatrix_Row(c_wm)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k, s, win, slide, incol, outcol, outrow, rep, wm;
    bit toggle;
    int exp_out, exp_in;
    logic [63:0] f0, f1, f2, f3, fin;
  } vec_t;

  vec_t vecs[6];
  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] got_data[$];
  bit got_last[$];
  logic [63:0] exp_q[$];
  int in_cnt, stall_err, extra_out, tail_in, timed_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pix(input int row, input int col);
    return 64'(row) * 64'd256 + 64'(col);
  endfunction

  task automatic apply_cfg(input vec_t v);
    c_k = 16'(v.k); c_stride = 16'(v.s); c_win = 16'(v.win); c_slide = 16'(v.slide);
    c_incol = 16'(v.incol); c_outcol = 16'(v.outcol); c_outrow = 16'(v.outrow);
    c_rep = 16'(v.rep); c_wm = 16'(v.wm); c_outfs = 16'(v.outcol * 8);
    c_infs = 16'(v.incol); c_inch = 16'd8; c_outch = 16'd8;
  endtask

  // Reference ordering: output row, group, replay, window, kernel row, beat.
  task automatic build_expected(input vec_t v);
    exp_q.delete();
    for (int r = 0; r < v.outrow; r++)
      for (int g = 0; g < v.outcol; g++)
        for (int p = 0; p < v.rep; p++)
          for (int w = 0; w < 8; w++)
            for (int kr = 0; kr < v.k; kr++)
              for (int b = 0; b < v.win; b++)
                exp_q.push_back(pix(r * v.s + kr, g * 8 * v.slide + w * v.slide + b));
  endtask

  // Holds start for n cycles; leaves start high so run_frame drops it on its first cycle.
  task automatic pulse_start(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b1; s_if.tvalid = 1'b1; m_if.tready = 1'b1;
      #1;
      if (s_if.tready || m_if.tvalid || m_if.tlast) bad++;
    end
  endtask

  task automatic run_frame(input int incol, input bit toggle, input int max_out, input int budget);
    bit seen_last = 1'b0;
    bit prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    got_data.delete(); got_last.delete();
    in_cnt = 0; stall_err = 0; extra_out = 0; tail_in = 0; timed_out = 1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata = pix(in_cnt / incol, in_cnt % incol);
      m_if.tready = toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      if (prev_stall && (!m_if.tvalid || m_if.tdata !== prev_data)) stall_err++;
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data = m_if.tdata;
      if (s_if.tvalid && s_if.tready) in_cnt++;
      if (m_if.tvalid && m_if.tready) begin
        got_data.push_back(m_if.tdata);
        got_last.push_back(m_if.tlast);
        if (m_if.tlast) seen_last = 1'b1;
      end
      if (seen_last || got_data.size() == max_out) begin
        timed_out = 0;
        break;
      end
    end
    if (seen_last) begin
      for (int cyc = 0; cyc < 20; cyc++) begin
        @(negedge clk);
        s_if.tvalid = 1'b1; m_if.tready = 1'b1;
        #1;
        if (s_if.tready) tail_in++;
        if (m_if.tvalid) extra_out++;
      end
    end
  endtask

  task automatic check_frame(input string tag, input vec_t v);
    int bad_i = -1;
    int last_pos = -1;
    int last_cnt = 0;
    chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
    chk({tag, "_out_count"}, 64'(got_data.size()), 64'(v.exp_out));
    chk({tag, "_in_count"}, 64'(in_cnt), 64'(v.exp_in));
    chk({tag, "_beat0"}, got_data.size() > 0 ? got_data[0] : 64'hDEAD, v.f0);
    chk({tag, "_beat1"}, got_data.size() > 1 ? got_data[1] : 64'hDEAD, v.f1);
    chk({tag, "_beat2"}, got_data.size() > 2 ? got_data[2] : 64'hDEAD, v.f2);
    chk({tag, "_beat3"}, got_data.size() > 3 ? got_data[3] : 64'hDEAD, v.f3);
    chk({tag, "_final"}, got_data.size() > 0 ? got_data[got_data.size()-1] : 64'hDEAD, v.fin);
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_data.size() || got_data[i] !== exp_q[i]) begin bad_i = i; break; end
    chk({tag, "_seq_first_bad_idx"}, 64'(bad_i), 64'(-1));
    for (int i = 0; i < got_last.size(); i++)
      if (got_last[i]) begin last_cnt++; if (last_pos < 0) last_pos = i; end
    chk({tag, "_tlast_pos"}, 64'(last_pos), 64'(v.exp_out - 1));
    chk({tag, "_tlast_count"}, 64'(last_cnt), 64'd1);
    chk({tag, "_stall_stable"}, 64'(stall_err), 64'd0);
    chk({tag, "_done_no_extra"}, 64'(extra_out + tail_in), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    reset = 1'b1; start = 1'b0; sw_conv = 1'b1; m2i = 1'b0;
    s_if.tdata = 64'h55; s_if.tvalid = 1'b1; s_if.tlast = 1'b0; s_if.tkeep = '1;
    m_if.tready = 1'b1;
    vecs[0] = '{2, 2, 2, 2, 16, 1, 1, 1, 32, 1'b0, 32, 32, 64'h000, 64'h001, 64'h100, 64'h101, 64'h10F};
    vecs[1] = '{2, 2, 2, 2, 16, 1, 1, 2, 32, 1'b0, 64, 32, 64'h000, 64'h001, 64'h100, 64'h101, 64'h10F};
    vecs[2] = '{3, 1, 3, 1, 16, 1, 2, 1, 72, 1'b0, 144, 64, 64'h000, 64'h001, 64'h002, 64'h100, 64'h309};
    vecs[3] = '{2, 2, 2, 2, 16, 1, 1, 1, 32, 1'b1, 32, 32, 64'h000, 64'h001, 64'h100, 64'h101, 64'h10F};
    vecs[4] = '{2, 2, 2, 2, 32, 2, 1, 1, 32, 1'b0, 64, 64, 64'h000, 64'h001, 64'h100, 64'h101, 64'h11F};
    vecs[5] = '{3, 1, 3, 1, 16, 1, 2, 1, 72, 1'b1, 144, 64, 64'h000, 64'h001, 64'h002, 64'h100, 64'h309};
    apply_cfg(vecs[0]);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_s_tready", 64'(s_if.tready), 64'd0);
    chk("reset_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("reset_m_tlast", 64'(m_if.tlast), 64'd0);
    chk("reset_m_tdata", m_if.tdata, 64'd0);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("idle_s_tready", 64'(s_if.tready), 64'd0);
    chk("idle_m_tvalid", 64'(m_if.tvalid), 64'd0);

    @(negedge clk);
    sw_conv = 1'b0; s_if.tdata = 64'h0102030405060708; s_if.tvalid = 1'b1; m_if.tready = 1'b1;
    #1;
    chk("byp_tdata", m_if.tdata, 64'h0102030405060708);
    chk("byp_tvalid", 64'(m_if.tvalid), 64'd1);
    chk("byp_s_tready_hi", 64'(s_if.tready), 64'd1);
    chk("byp_tlast", 64'(m_if.tlast), 64'd0);
    m_if.tready = 1'b0; #1;
    chk("byp_s_tready_lo", 64'(s_if.tready), 64'd0);
    s_if.tvalid = 1'b0; #1;
    chk("byp_tvalid_lo", 64'(m_if.tvalid), 64'd0);
    sw_conv = 1'b1; m2i = 1'b1; s_if.tdata = 64'hA5A5_0000_FFFF_1234; s_if.tvalid = 1'b1; m_if.tready = 1'b1;
    #1;
    chk("m2i_byp_tdata", m_if.tdata, 64'hA5A5_0000_FFFF_1234);
    chk("m2i_byp_s_tready", 64'(s_if.tready), 64'd1);
    @(negedge clk); m2i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      apply_cfg(vecs[i]);
      build_expected(vecs[i]);
      pulse_start(3, bad);
      chk({tag, "_start_quiet"}, 64'(bad), 64'd0);
      run_frame(vecs[i].incol, vecs[i].toggle, 100000, 2000);
      check_frame(tag, vecs[i]);
    end

    apply_cfg(vecs[0]);
    build_expected(vecs[0]);
    pulse_start(3, bad);
    run_frame(vecs[0].incol, 1'b0, 10, 500);
    chk("rst_pre_beats", 64'(got_data.size()), 64'd10);
    chk("rst_pre_in", 64'(in_cnt), 64'd32);
    pulse_start(20, bad);
    chk("restart_quiet", 64'(bad), 64'd0);
    run_frame(vecs[0].incol, 1'b0, 100000, 2000);
    check_frame("restart", vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_img2col_stream.md
Name: conv_img2col_stream

Overview:
Streaming Img2Col front-end of the convolution engine. Takes a row-major, channel-packed feature map on an AXI-Stream slave (8 channel bytes per 64-bit beat) and buffers K input rows in an on-chip circular row buffer. It emits the Img2Col matrix, one kernel window after another, on an AXI-Stream master that feeds the MAC array. A bypass mode forwards the input stream unchanged.

Parameters:
DATA_W, 64, stream beat width (8 bytes).
MAX_K, 3, maximum kernel size; number of row-buffer slots.
MAX_ROW_BEATS, 2048, maximum beats per input row; slot stride in the row RAM.
GROUP_W, 8, output windows per column group.
CFG_W, 16, width of every Img2Col_* configuration port.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
Control_start  in  1  start/restart; level, may be held several cycles
Control_Switch_Conv  in  1  1 = Img2Col mode, 0 = bypass
Control_Matrix2Img  in  1  1 forces bypass (reserved mode)
s_axis_s2mm_tdata  in  64  input beat
s_axis_s2mm_tvalid  in  1  input valid
s_axis_s2mm_tready  out  1  input ready
m_axis_mm2s_tdata  out  64  output beat
m_axis_mm2s_tvalid  out  1  output valid
m_axis_mm2s_tready  in  1  output ready
m_axis_mm2s_tlast  out  1  last beat of the frame
m_axis_mm2s_tkeep  out  8  constant 8'hFF
Img2Col_Stride  in  CFG_W  S, rows/cols per step; 1 <= S <= K
Img2Col_Kernel_Size  in  CFG_W  K, 1..MAX_K
Img2Col_Window_Size  in  CFG_W  K*C/8, beats per kernel row
Img2Col_InFeature_Size  in  CFG_W  padded input width (informational)
Img2Col_InFeature_Channel  in  CFG_W  C, multiple of 8 (informational)
Img2Col_OutFeature_Channel  in  CFG_W  output channels (informational)
Img2Col_OutFeature_Size  in  CFG_W  output width; equals OutCol_Count_Times*GROUP_W
Img2Col_Sliding_Size  in  CFG_W  S*C/8, beat step between adjacent windows
Img2Col_OutCol_Count_Times  in  CFG_W  column groups per output row
Img2Col_InCol_Count_Times  in  CFG_W  beats per input row, <= MAX_ROW_BEATS
Img2Col_OutRow_Count_Times  in  CFG_W  output rows
Img2Col_OutFeature_Channel_Count_Times  in  CFG_W  R, replays of each group
Img2Col_WeightMatrix_Row  in  CFG_W  K*K*C bytes; beats per window = value>>3

Behaviour:
- Reset: state IDLE. All counters are 0. s_axis_s2mm_tready=0, m_axis_mm2s_tvalid=0, m_axis_mm2s_tlast=0, m_axis_mm2s_tdata=0.
- Mode: bypass when Control_Switch_Conv=0 or Control_Matrix2Img=1.
  - Bypass is combinational: m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready, m_tlast=0.
  - Img2Col FSM held in IDLE while in bypass.
- Any cycle with Control_start=1 (Img2Col mode), in any state:
  - Latch all Img2Col_* ports; clear counters; slot pointer=0.
  - Drop any pending output: m_tvalid=0, m_tlast=0.
  - Hold s_tready=0. Enter LOAD on the first cycle Control_start=0.
- LOAD: s_tready=1.
  - Each beat with s_tvalid&&s_tready is written to RAM[slot*MAX_ROW_BEATS+col].
  - col wraps at InCol_Count_Times; then slot advances mod K.
  - Rows required: K before output row 0, S before each later output row.
  - When the required rows are in, go to EMIT with s_tready=0. EMIT's row base = the oldest valid slot.
- EMIT: nested order, outer to inner:
  - output row r < OutRow_Count_Times; group g < OutCol_Count_Times; replay p < R; window w < GROUP_W; kernel row kr < K; beat b < Window_Size.
  - Read address: slot = (base+kr) mod K; col = g*GROUP_W*Sliding_Size + w*Sliding_Size + b.
  - A window ends after WeightMatrix_Row>>3 beats (must equal K*Window_Size).
- EMIT output timing:
  - RAM read latency 1 cycle; output register; first m_tvalid 2 cycles after entering EMIT.
  - Data is held stable while m_tvalid=1 and m_tready=0; no beat is lost or duplicated.
  - Full throughput (1 beat/cycle) when m_tready=1.
- End of output row: if r < OutRow-1, base += S (mod K) and return to LOAD for S rows; else go to DONE.
- m_tlast=1 only on the final beat of the final output row.
- DONE: s_tready=0; input beats beyond the (OutRow-1)*S+K rows consumed are not accepted. Stay until the next Control_start.
- Arithmetic: unsigned, counters CFG_W bits, RAM address fits log2(MAX_K*MAX_ROW_BEATS).
- Inconsistent configuration is out of scope (undefined output, no hang required).
- Reset mid-operation aborts immediately to the reset state.

Test Plan:
- Bypass, Switch_Conv=0, m_tready=1, input 0x0102030405060708 -> same value on m_tdata in the same cycle; s_tready follows m_tready.
- Small conv, K=2, S=2, C=8 (Window=2, Sliding=2), InCol=16, OutSize=8, OutCol=1, OutRow=1, R=1, WMRow=32. Input beat value = row*16+col.
  -> 32 output beats: 0,1,16,17, 2,3,18,19, ... 14,15,30,31; tlast on beat 32; s_tready low after 32 input beats.
- Same config with R=2 -> 64 beats, the 32-beat sequence twice; tlast only on beat 64.
- Multi-row, K=3, S=1, OutRow=2, InCol=16, OutSize=8 -> row 1 uses input rows 1..3. Exactly 1 extra row is loaded between output rows; total inputs 64.
- Backpressure: toggle m_tready every cycle -> output sequence identical to the full-rate run, each beat stable while stalled.
- Restart: assert Control_start mid-EMIT for 20 cycles -> output stops, s_tready=0 during start, then a fresh frame from input row 0.
